riscv_aes_operand_bank: RTL and testbench

- Parametrised, multi-context successor to the AES data/key register file in the RISC-V core.
- Holds NUM_CTX independent operand sets; each set is a data block plus a key of up to 256 bits.
- Runs a request/grant/done handshake with the AES engine and writes the engine result back into the data words.
- Locks the launched context while an operation is in flight and reports protocol errors.

---
 rtl/riscv_aes_operand_bank.sv | 166 ++++++++++++++++
 tb/tb_riscv_aes_operand_bank.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_aes_operand_bank.sv
// Multi-context AES data/key operand bank with request/grant/done engine handshake.
// Ports: clk, rst (sync, active-high); write port waddr_i/wdata_i/wen_i/sel_i/ctx_i;
//   start_i/key_len_i launch; aes_req_o/aes_gnt_i/aes_done_i/aes_result_i engine side;
//   data_o/key_o/key_len_o show the active context; busy_o/done_o status; err_o sticky error.
//   Optional macro AES_OPERAND_KEY_ZEROIZE_EN clears the active key on completion.
module riscv_aes_operand_bank #(
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_DATA_WORDS = 4,
   parameter int NUM_KEY_WORDS  = 8,
   parameter int NUM_CTX        = 2,
   parameter int ADDR_WIDTH     = $clog2(NUM_KEY_WORDS),
   parameter int CTX_WIDTH      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [ADDR_WIDTH-1:0]              waddr_i,
   input  logic [DATA_WIDTH-1:0]              wdata_i,
   input  logic                               wen_i,
   input  logic [1:0]                         sel_i,
   input  logic [CTX_WIDTH-1:0]               ctx_i,
   input  logic [1:0]                         key_len_i,
   input  logic                               start_i,
   output logic                               aes_req_o,
   input  logic                               aes_gnt_i,
   input  logic                               aes_done_i,
   input  logic [NUM_DATA_WORDS*DATA_WIDTH-1:0] aes_result_i,
   output logic [NUM_DATA_WORDS*DATA_WIDTH-1:0] data_o,
   output logic [NUM_KEY_WORDS*DATA_WIDTH-1:0]  key_o,
   output logic [1:0]                         key_len_o,
   output logic                               busy_o,
   output logic                               done_o,
   output logic                               err_o
);

   typedef enum logic [1:0] {IDLE, REQ, BUSY, WB} state_e;

   state_e                state_q, state_d;
   logic [CTX_WIDTH-1:0]  ctx_q, ctx_d;
   logic [1:0]            klen_q, klen_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] data_q [NUM_CTX][NUM_DATA_WORDS];
   logic [DATA_WIDTH-1:0] data_d [NUM_CTX][NUM_DATA_WORDS];
   logic [DATA_WIDTH-1:0] key_q  [NUM_CTX][NUM_KEY_WORDS];
   logic [DATA_WIDTH-1:0] key_d  [NUM_CTX][NUM_KEY_WORDS];

   logic sel_data, sel_key, ctx_ok, addr_ok, locked, wr_ok, wr_err;

   assign sel_data = (sel_i == 2'b01);
   assign sel_key  = (sel_i == 2'b10);
   assign busy_o   = (state_q != IDLE);
   assign locked   = busy_o && (ctx_i == ctx_q);

   // ctx_i may exceed NUM_CTX-1 when NUM_CTX is not a power of two
   always_comb begin
      ctx_ok = 1'b0;
      for (int c = 0; c < NUM_CTX; c++)
         if (32'(ctx_i) == 32'(c)) ctx_ok = 1'b1;
   end

   assign addr_ok = sel_data ? (32'(waddr_i) < 32'(NUM_DATA_WORDS))
                             : (32'(waddr_i) < 32'(NUM_KEY_WORDS));
   assign wr_ok   = wen_i && (sel_data || sel_key) && addr_ok && ctx_ok && !locked;
   assign wr_err  = wen_i && ((sel_i == 2'b11) ||
                    ((sel_data || sel_key) && (!addr_ok || !ctx_ok || locked)));

   always_comb begin
      state_d = state_q;
      ctx_d   = ctx_q;
      klen_d  = klen_q;
      err_d   = err_q;
      data_d  = data_q;
      key_d   = key_q;

      if (wr_err) err_d = 1'b1;

      for (int c = 0; c < NUM_CTX; c++) begin
         for (int w = 0; w < NUM_DATA_WORDS; w++)
            if (wr_ok && sel_data && 32'(ctx_i) == 32'(c) && 32'(waddr_i) == 32'(w))
               data_d[c][w] = wdata_i;
         for (int k = 0; k < NUM_KEY_WORDS; k++)
            if (wr_ok && sel_key && 32'(ctx_i) == 32'(c) && 32'(waddr_i) == 32'(k))
               key_d[c][k] = wdata_i;
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (key_len_i == 2'b11 || !ctx_ok) begin
                  err_d = 1'b1;
               end else begin
                  ctx_d   = ctx_i;
                  klen_d  = key_len_i;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (aes_gnt_i) state_d = BUSY;
         end
         BUSY: begin
            if (aes_done_i) begin
               state_d = WB;
               // result capture and optional key wipe share the edge into WB
               for (int c = 0; c < NUM_CTX; c++) begin
                  if (32'(ctx_q) == 32'(c)) begin
                     for (int w = 0; w < NUM_DATA_WORDS; w++)
                        data_d[c][w] = aes_result_i[w*DATA_WIDTH +: DATA_WIDTH];
`ifdef AES_OPERAND_KEY_ZEROIZE_EN
                     for (int k = 0; k < NUM_KEY_WORDS; k++)
                        key_d[c][k] = '0;
`endif
                  end
               end
            end
         end
         WB: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (start_i && state_q != IDLE)    err_d = 1'b1;
      if (aes_done_i && state_q != BUSY) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ctx_q   <= '0;
         klen_q  <= '0;
         err_q   <= 1'b0;
         for (int c = 0; c < NUM_CTX; c++) begin
            for (int w = 0; w < NUM_DATA_WORDS; w++) data_q[c][w] <= '0;
            for (int k = 0; k < NUM_KEY_WORDS; k++)  key_q[c][k]  <= '0;
         end
      end else begin
         state_q <= state_d;
         ctx_q   <= ctx_d;
         klen_q  <= klen_d;
         err_q   <= err_d;
         data_q  <= data_d;
         key_q   <= key_d;
      end
   end

   always_comb begin
      data_o = '0;
      key_o  = '0;
      for (int c = 0; c < NUM_CTX; c++) begin
         if (32'(ctx_q) == 32'(c)) begin
            for (int w = 0; w < NUM_DATA_WORDS; w++)
               data_o[w*DATA_WIDTH +: DATA_WIDTH] = data_q[c][w];
            for (int k = 0; k < NUM_KEY_WORDS; k++)
               key_o[k*DATA_WIDTH +: DATA_WIDTH] = key_q[c][k];
         end
      end
   end

   assign aes_req_o = (state_q == REQ);
   assign done_o    = (state_q == WB);
   assign key_len_o = klen_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_riscv_aes_operand_bank.sv
// Directed self-checking bench for riscv_aes_operand_bank.
// Default parameters: 2 contexts, 4 data words, 8 key words of 32 bits.
module tb_riscv_aes_operand_bank;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [2:0]   waddr_i = '0;
   logic [31:0]  wdata_i = '0;
   logic         wen_i = 1'b0;
   logic [1:0]   sel_i = '0;
   logic [0:0]   ctx_i = '0;
   logic [1:0]   key_len_i = '0;
   logic         start_i = 1'b0;
   logic         aes_req_o;
   logic         aes_gnt_i = 1'b0;
   logic         aes_done_i = 1'b0;
   logic [127:0] aes_result_i = '0;
   logic [127:0] data_o;
   logic [255:0] key_o;
   logic [1:0]   key_len_o;
   logic         busy_o, done_o, err_o;

   int checks = 0;
   int errors = 0;

   logic [127:0] exp_data;
   logic [255:0] exp_key;

   riscv_aes_operand_bank dut (
      .clk(clk), .rst(rst), .waddr_i(waddr_i), .wdata_i(wdata_i),
      .wen_i(wen_i), .sel_i(sel_i), .ctx_i(ctx_i), .key_len_i(key_len_i),
      .start_i(start_i), .aes_req_o(aes_req_o), .aes_gnt_i(aes_gnt_i),
      .aes_done_i(aes_done_i), .aes_result_i(aes_result_i),
      .data_o(data_o), .key_o(key_o), .key_len_o(key_len_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wr(input logic [0:0] c, input logic [1:0] s,
                     input logic [2:0] a, input logic [31:0] d);
      ctx_i = c; sel_i = s; waddr_i = a; wdata_i = d; wen_i = 1'b1;
      tick();
      wen_i = 1'b0; sel_i = 2'b00;
   endtask

   task automatic launch(input logic [0:0] c, input logic [1:0] kl);
      ctx_i = c; key_len_i = kl; start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++; if (data_o !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", data_o); end
      checks++; if (key_o !== '0) begin errors++; $display("FAIL rst_key got=%h exp=0", key_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err_o); end
      checks++; if ({aes_req_o, done_o} !== 2'b00) begin errors++; $display("FAIL rst_req_done got=%b exp=00", {aes_req_o, done_o}); end
   endtask

   task automatic test_load_run();
      wr(1'b0, 2'b01, 3'd0, 32'hDEADBEEF);
      wr(1'b0, 2'b01, 3'd1, 32'hDEAFBABE);
      wr(1'b0, 2'b01, 3'd2, 32'hCAFEFACE);
      wr(1'b0, 2'b01, 3'd3, 32'h01234567);
      for (int i = 0; i < 8; i++) begin
         wr(1'b0, 2'b10, 3'(i), 32'hC0DE0000 + 32'(i));
         exp_key[i*32 +: 32] = 32'hC0DE0000 + 32'(i);
      end
      exp_data = {32'h01234567, 32'hCAFEFACE, 32'hDEAFBABE, 32'hDEADBEEF};
      checks++; if (data_o !== exp_data) begin errors++; $display("FAIL load_data got=%h exp=%h", data_o, exp_data); end
      checks++; if (key_o !== exp_key) begin errors++; $display("FAIL load_key got=%h exp=%h", key_o, exp_key); end
      launch(1'b0, 2'b10);
      checks++; if (aes_req_o !== 1'b1) begin errors++; $display("FAIL run_req got=%b exp=1", aes_req_o); end
      checks++; if (key_len_o !== 2'b10) begin errors++; $display("FAIL run_klen got=%b exp=10", key_len_o); end
      aes_gnt_i = 1'b1; tick(); aes_gnt_i = 1'b0;
      checks++; if ({aes_req_o, busy_o} !== 2'b01) begin errors++; $display("FAIL run_gnt got=%b exp=01", {aes_req_o, busy_o}); end
      aes_result_i = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      aes_done_i = 1'b1; tick(); aes_done_i = 1'b0;
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL run_done got=%b exp=1", done_o); end
      checks++; if (data_o[31:0] !== 32'h11111111) begin errors++; $display("FAIL run_word0 got=%h exp=11111111", data_o[31:0]); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL run_wb_busy got=%b exp=1", busy_o); end
      tick();
      checks++; if ({busy_o, done_o} !== 2'b00) begin errors++; $display("FAIL run_idle got=%b exp=00", {busy_o, done_o}); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL run_err got=%b exp=0", err_o); end
`ifdef AES_OPERAND_KEY_ZEROIZE_EN
      exp_key = '0;
`endif
      checks++; if (key_o !== exp_key) begin errors++; $display("FAIL zeroize_key got=%h exp=%h", key_o, exp_key); end
   endtask

   task automatic test_lock();
      launch(1'b0, 2'b00);
      aes_gnt_i = 1'b1; tick(); aes_gnt_i = 1'b0;
      wr(1'b0, 2'b01, 3'd1, 32'hAAAAAAAA);
      wr(1'b1, 2'b01, 3'd1, 32'hBBBBBBBB);
      exp_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      checks++; if (data_o !== exp_data) begin errors++; $display("FAIL lock_ctx0 got=%h exp=%h", data_o, exp_data); end
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL lock_err got=%b exp=1", err_o); end
      aes_result_i = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
      aes_done_i = 1'b1; tick(); aes_done_i = 1'b0;
      checks++; if (data_o !== aes_result_i) begin errors++; $display("FAIL lock_result got=%h exp=%h", data_o, aes_result_i); end
      tick();
      launch(1'b1, 2'b00);
      exp_data = {32'h0, 32'h0, 32'hBBBBBBBB, 32'h0};
      checks++; if (data_o !== exp_data) begin errors++; $display("FAIL lock_ctx1 got=%h exp=%h", data_o, exp_data); end
   endtask

   task automatic test_errors();
      do_reset();
      launch(1'b0, 2'b00);
      launch(1'b0, 2'b00);
      checks++; if ({err_o, aes_req_o} !== 2'b11) begin errors++; $display("FAIL err_start_busy got=%b exp=11", {err_o, aes_req_o}); end
      do_reset();
      launch(1'b0, 2'b11);
      checks++; if ({err_o, busy_o} !== 2'b10) begin errors++; $display("FAIL err_klen got=%b exp=10", {err_o, busy_o}); end
      do_reset();
      wr(1'b0, 2'b01, 3'd5, 32'h12345678);
      checks++; if ({err_o, data_o} !== {1'b1, 128'h0}) begin errors++; $display("FAIL err_addr got=%b/%h exp=1/0", err_o, data_o); end
      do_reset();
      aes_result_i = 128'hFFFF;
      aes_done_i = 1'b1; tick(); aes_done_i = 1'b0;
      checks++; if ({err_o, data_o} !== {1'b1, 128'h0}) begin errors++; $display("FAIL err_done_idle got=%b/%h exp=1/0", err_o, data_o); end
      do_reset();
      wr(1'b0, 2'b11, 3'd0, 32'h1);
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sel11 got=%b exp=1", err_o); end
      do_reset();
      aes_gnt_i = 1'b1; tick(); aes_gnt_i = 1'b0;
      checks++; if ({err_o, busy_o} !== 2'b00) begin errors++; $display("FAIL gnt_idle got=%b exp=00", {err_o, busy_o}); end
   endtask

   task automatic test_write_start_same_cycle();
      do_reset();
      ctx_i = 1'b0; sel_i = 2'b01; waddr_i = 3'd2; wdata_i = 32'h12345678; wen_i = 1'b1;
      key_len_i = 2'b01; start_i = 1'b1;
      tick();
      wen_i = 1'b0; sel_i = 2'b00; start_i = 1'b0;
      checks++; if (data_o[95:64] !== 32'h12345678) begin errors++; $display("FAIL ws_data got=%h exp=12345678", data_o[95:64]); end
      checks++; if ({aes_req_o, err_o, key_len_o} !== 4'b1001) begin errors++; $display("FAIL ws_start got=%b exp=1001", {aes_req_o, err_o, key_len_o}); end
   endtask

   task automatic test_reset_midop();
      do_reset();
      wr(1'b0, 2'b01, 3'd0, 32'hA5A5A5A5);
      launch(1'b0, 2'b00);
      aes_gnt_i = 1'b1; tick(); aes_gnt_i = 1'b0;
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got=%b exp=1", busy_o); end
      rst = 1'b1; tick(); rst = 1'b0;
      checks++; if ({busy_o, data_o} !== {1'b0, 128'h0}) begin errors++; $display("FAIL mid_clear got=%b/%h exp=0/0", busy_o, data_o); end
      aes_result_i = 128'h1;
      aes_done_i = 1'b1; tick(); aes_done_i = 1'b0;
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mid_done1 got=%b exp=0", done_o); end
      tick();
      checks++; if ({done_o, data_o} !== {1'b0, 128'h0}) begin errors++; $display("FAIL mid_done2 got=%b/%h exp=0/0", done_o, data_o); end
   endtask

   initial begin
      test_reset();
      test_load_run();
      test_lock();
      test_errors();
      test_write_start_same_cycle();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
